// File: rtl/mem_pkg.sv
// Shared types, constants and the read/write arbitration rule for the
// memory controller slice.
package mem_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        TURN
    } mem_state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    // A lone request always wins. A contested cycle goes to the type that
    // did not win the previous contest, so neither channel can starve.
    function automatic grant_t pick_grant(input logic i_rd, input logic i_wr,
                                          input grant_t i_last);
        if (i_rd && i_wr) begin
            return (i_last == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
        end
        return i_rd ? GRANT_READ : GRANT_WRITE;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM. The address is registered, so read data
// appears in the cycle after the address is presented.
module sp_ram
    import mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_addr;

    // NOTE: the storage array has no reset. Clearing it would turn the array
    // into plain flops and defeat RAM inference, and its contents must
    // survive a controller reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_addr <= addr;
    end

    assign dout = r_mem[r_addr];

endmodule

// File: rtl/memory_controller.sv
// Serves one read channel and one write channel from a single-port RAM:
// arbitrates, performs the access, and returns a one-cycle ready pulse.
module memory_controller
    import mem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_ready,
    output logic [DATA_WIDTH-1:0] read_value,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_value,
    output logic                  write_ready
);

    localparam int                  RAM_AW   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    mem_state_t            r_state;
    mem_state_t            w_next_state;
    grant_t                r_last_grant;
    grant_t                w_next_last_grant;
    grant_t                w_grant;
    logic                  w_accept_rd;
    logic                  w_accept_wr;
    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic                  w_ram_we;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_dout;
    logic                  r_read_ready;
    logic                  r_write_ready;
    logic                  r_rd_oob;
    logic [DATA_WIDTH-1:0] r_read_value;

    assign w_rd_in_range = ({1'b0, read_address} < LP_DEPTH);
    assign w_wr_in_range = ({1'b0, write_address} < LP_DEPTH);
    assign w_grant       = pick_grant(read, write, r_last_grant);

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_accept_rd       = 1'b0;
        w_accept_wr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (read || write) begin
                    if (w_grant == GRANT_WRITE) begin
                        w_accept_wr  = 1'b1;
                        w_next_state = TURN;
                    end else begin
                        w_accept_rd  = 1'b1;
                        w_next_state = RD_DATA;
                    end
                    if (read && write) begin
                        w_next_last_grant = w_grant;
                    end
                end
            end
            RD_DATA: w_next_state = TURN;
            TURN:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Out-of-range writes still take the TURN slot and get acknowledged.
    assign w_ram_we   = w_accept_wr && w_wr_in_range && !reset;
    assign w_ram_addr = w_accept_wr ? write_address[RAM_AW-1:0]
                                    : read_address[RAM_AW-1:0];

    sp_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(RAM_AW)
    ) u_ram (
        .clk (clk),
        .we  (w_ram_we),
        .addr(w_ram_addr),
        .din (write_value),
        .dout(w_ram_dout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_WRITE;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_ready  <= 1'b0;
            r_write_ready <= 1'b0;
            r_rd_oob      <= 1'b0;
            r_read_value  <= '0;
        end else begin
            r_write_ready <= w_accept_wr;
            r_read_ready  <= (r_state == RD_DATA);
            if (w_accept_rd) begin
                r_rd_oob <= !w_rd_in_range;
            end
            if (r_state == RD_DATA) begin
                r_read_value <= r_rd_oob ? '0 : w_ram_dout;
            end
        end
    end

    assign read_ready  = r_read_ready;
    assign write_ready = r_write_ready;
    assign read_value  = r_read_value;

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
Memory-side stage that serves the MemoryAccessor read and write request channels from one single-port synchronous RAM of 16-bit words. It arbitrates between a pending read and a pending write. It performs the RAM access and returns a one-cycle ready pulse to the requester, with read data on reads. It sits directly downstream of the MemoryAccessor interface. The CPU core drives the read and write channels, and this block answers them.

Parameters:
- DEPTH, 256, number of 16-bit words; word-addressed; legal addresses are 0..DEPTH-1.
- ADDR_WIDTH, `ARCH_SIZE, width of read_address and write_address.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  read request; level, held until read_ready is seen.
- read_address  input  ADDR_WIDTH  word address of the read; stable while read is high.
- read_ready  output  1  one-cycle pulse; read_value is valid in that cycle.
- read_value  output  16  registered read data; holds its value until the next read completes.
- write  input  1  write request; level, held until write_ready is seen.
- write_address  input  ADDR_WIDTH  word address of the write; stable while write is high.
- write_value  input  16  write data; stable while write is high.
- write_ready  output  1  one-cycle pulse; the write has been committed.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, read_ready=0, write_ready=0, read_value=16'h0000, last_grant=WRITE.
  - RAM contents are not cleared.
  - Reset mid-operation abandons any in-flight access; no ready pulse follows.
  - A write already committed at an earlier edge stays in the RAM.
- FSM states: IDLE, RD_DATA, TURN.
- IDLE:
  - Samples read and write.
  - Only write high: write_value is written at that edge; next state TURN; write_ready=1 in the next cycle.
  - Only read high: read_address is registered into the RAM; next state RD_DATA.
  - Both high: grant the type opposite to last_grant, then update last_grant. The first contested grant after reset goes to read. The loser stays pending.
  - Neither high: stay in IDLE.
- RD_DATA: RAM output is valid. At the edge, read_value takes the RAM output; next state TURN; read_ready=1 in the next cycle.
- TURN: the ready pulse is high here. No request is accepted; next state IDLE. Requesters must drop or replace their request by the cycle after the ready pulse.
- Latency, counting the cycle in IDLE where the request is sampled as cycle 0:
  - Write: write_ready high in cycle 1; accepts again in cycle 2.
  - Read: read_ready high in cycle 2; accepts again in cycle 3.
- Ready pulses are exactly one cycle long. read_ready and write_ready are never high in the same cycle.
- Out-of-range address (>= DEPTH): reads return 16'h0000; writes are dropped but still acknowledged with write_ready. Timing is identical to in-range accesses.
- Read-after-write to the same address: the read accepted after a write's TURN returns the new data. Single port, strictly serialized, no bypass needed.
- A request that drops before being granted is forgotten; the block has no side effect from it.
- Worst-case service: a pending request waits at most one opposing access. With continuous traffic on both channels, grants alternate.

Decomposition:
- Package mem_pkg:
  - DATA_WIDTH=16.
  - typedef enum mem_state_t {IDLE, RD_DATA, TURN}.
  - typedef enum grant_t {GRANT_READ, GRANT_WRITE}.
- Sub-module sp_ram: single-port synchronous RAM with DEPTH x 16 bits, ports we/addr/din/dout, registered-address read. memory_controller instantiates one sp_ram and holds the FSM, the arbiter, the range check and the output registers.

Test Plan:
- Reset, then write=1, address 5, value 16'hBEEF -> write_ready=1 exactly in cycle 1 for one cycle. Then read address 5 -> read_ready in cycle 2 with read_value=16'hBEEF.
- Raise read (address 5) and write (address 6, value 16'h1234) in the same cycle after reset -> read is granted first: read_ready at +2, then write_ready at +4. Holding both requests high with new values continues the alternation: write, read, write.
- Read address DEPTH+3 -> read_ready at +2 with 16'h0000. Write 16'hFFFF to address DEPTH -> write_ready at +1, and address 0 is unchanged.
- Assert reset in the RD_DATA cycle of a read -> no read_ready follows, read_value=0, state IDLE. The next read of a previously written address returns the correct data.
- Back-to-back writes to addresses 0..7 with values 16'h0100+i, each request held until its ready pulse -> each ack arrives 2 cycles after the previous one. Reading them back returns 16'h0100+i.
- Hold read high through its read_ready and TURN -> no second access is started until IDLE. Exactly one read is served per request held across the turnaround.
